// File: rtl/rgmii_receive_controller.sv
// RGMII 1000M receive sequencer: strips preamble/SFD, emits the payload as a
// valid/last/error byte stream, decodes in-band link status and counts frames.
module rgmii_receive_controller #(
  parameter int MAX_PREAMBLE_BYTES = 7,
  parameter int MAX_FRAME_BYTES    = 1522,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [7:0]               ddr_data,
  input  logic [1:0]               ddr_control,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  output logic                     data_last,
  output logic                     data_error,
  output logic                     link_up,
  output logic [1:0]               link_speed,
  output logic                     full_duplex,
  output logic [COUNTER_WIDTH-1:0] good_frame_count,
  output logic [COUNTER_WIDTH-1:0] error_frame_count
);
  localparam int PW = $clog2(MAX_PREAMBLE_BYTES + 2);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [PW-1:0] MAX_PRE  = PW'(MAX_PREAMBLE_BYTES);
  localparam logic [BW-1:0] MAX_LEN  = BW'(MAX_FRAME_BYTES);
  localparam logic [7:0]    PRE_BYTE = 8'h55;
  localparam logic [7:0]    SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_e;

  logic [7:0] rx_byte;
  logic       rx_dv, rx_er;
  assign rx_byte = {ddr_data[3:0], ddr_data[7:4]};
  assign rx_dv   = ddr_control[1];
  assign rx_er   = ddr_control[1] ^ ddr_control[0];

  state_e                   state_q, state_d;
  logic [PW-1:0]            pre_cnt_q, pre_cnt_d;
  logic [BW-1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]               hold_q, hold_d;
  logic                     hold_vld_q, hold_vld_d;
  logic                     sticky_q, sticky_d;
  logic                     trunc_q, trunc_d;
  logic [7:0]               data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     data_last_q, data_last_d;
  logic                     data_error_q, data_error_d;
  logic                     link_up_q, link_up_d;
  logic [1:0]               link_speed_q, link_speed_d;
  logic                     full_duplex_q, full_duplex_d;
  logic [COUNTER_WIDTH-1:0] good_q, good_d;
  logic [COUNTER_WIDTH-1:0] bad_q, bad_d;
  logic                     good_inc, bad_inc;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    sticky_d      = sticky_q;
    trunc_d       = trunc_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    data_last_d   = 1'b0;
    data_error_d  = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    full_duplex_d = full_duplex_q;
    good_inc      = 1'b0;
    bad_inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        hold_vld_d = 1'b0;
        sticky_d   = 1'b0;
        trunc_d    = 1'b0;
        if (!rx_dv) begin
          // rx_er with rx_dv low is carrier extension / false carrier, not status
          if (!rx_er) begin
            link_up_d     = rx_byte[0];
            link_speed_d  = rx_byte[2:1];
            full_duplex_d = rx_byte[3];
          end
        end else if (rx_byte == PRE_BYTE) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PW'(1);
        end else if (rx_byte == SFD_BYTE) begin
          state_d = PAYLOAD;
        end else begin
          state_d = DROP;
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
          bad_inc = 1'b1;
        end else if (rx_byte == PRE_BYTE) begin
          if (pre_cnt_q >= MAX_PRE) state_d = DROP;
          else                      pre_cnt_d = pre_cnt_q + PW'(1);
        end else if (rx_byte == SFD_BYTE) begin
          state_d = PAYLOAD;
        end else begin
          state_d = DROP;
        end
      end
      PAYLOAD: begin
        if (rx_dv && byte_cnt_q == MAX_LEN) begin
          data_out_d   = hold_q;
          data_valid_d = 1'b1;
          data_last_d  = 1'b1;
          data_error_d = 1'b1;
          bad_inc      = 1'b1;
          trunc_d      = 1'b1;
          hold_vld_d   = 1'b0;
          state_d      = DROP;
        end else if (rx_dv) begin
          // one-byte hold lets the final byte be tagged last when rx_dv drops
          if (hold_vld_q) begin
            data_out_d   = hold_q;
            data_valid_d = 1'b1;
          end
          hold_d     = rx_byte;
          hold_vld_d = 1'b1;
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (rx_er) sticky_d = 1'b1;
        end else begin
          state_d = IDLE;
          if (hold_vld_q) begin
            data_out_d   = hold_q;
            data_valid_d = 1'b1;
            data_last_d  = 1'b1;
            data_error_d = sticky_q;
            good_inc     = !sticky_q;
            bad_inc      = sticky_q;
          end else begin
            bad_inc = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          state_d = IDLE;
          bad_inc = !trunc_q;
        end
      end
      default: state_d = IDLE;
    endcase
    good_d = good_q + COUNTER_WIDTH'(good_inc);
    bad_d  = bad_q + COUNTER_WIDTH'(bad_inc);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      sticky_q      <= 1'b0;
      trunc_q       <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      data_error_q  <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= '0;
      full_duplex_q <= 1'b0;
      good_q        <= '0;
      bad_q         <= '0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      sticky_q      <= sticky_d;
      trunc_q       <= trunc_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      data_last_q   <= data_last_d;
      data_error_q  <= data_error_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      full_duplex_q <= full_duplex_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
    end
  end

  assign data_out          = data_out_q;
  assign data_valid        = data_valid_q;
  assign data_last         = data_last_q;
  assign data_error        = data_error_q;
  assign link_up           = link_up_q;
  assign link_speed        = link_speed_q;
  assign full_duplex       = full_duplex_q;
  assign good_frame_count  = good_q;
  assign error_frame_count = bad_q;
endmodule

// File: doc/rgmii_receive_controller.md
Name: rgmii_receive_controller

Overview:
- Sequences the RGMII receive path at 1000 Mb/s, one byte per clock. Input is the demultiplexed data nibble pair and control pair produced by the DDR input capture stage.
- Strips preamble and SFD, then emits payload bytes as a valid/last/error stream to the switch ingress logic.
- Decodes in-band link status between frames and maintains good-frame and error-frame counters.

Parameters:
- MAX_PREAMBLE_BYTES, 7, maximum number of 0x55 bytes accepted before the SFD.
- MAX_FRAME_BYTES, 1522, maximum payload bytes after the SFD before the frame is truncated.
- COUNTER_WIDTH, 32, width of the frame counters.

Ports:
- clock  input  1  receive clock, RGMII RXC domain.
- reset_n  input  1  asynchronous active-low reset.
- ddr_data  input  8  {rising-edge nibble, falling-edge nibble}. Received byte = {ddr_data[3:0], ddr_data[7:4]}.
- ddr_control  input  2  {rising ctl, falling ctl}. rx_dv = ddr_control[1]; rx_er = ddr_control[1] ^ ddr_control[0].
- data_out  output  8  payload byte.
- data_valid  output  1  data_out valid this cycle (no backpressure).
- data_last  output  1  final byte of a frame, qualified by data_valid.
- data_error  output  1  frame errored, qualified by data_valid & data_last.
- link_up  output  1  in-band link status.
- link_speed  output  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- full_duplex  output  1  in-band duplex.
- good_frame_count  output  COUNTER_WIDTH  frames ended without error.
- error_frame_count  output  COUNTER_WIDTH  frames ended with error or dropped.

Behaviour:
- Clock and reset: all state uses clock. reset_n is asynchronous active-low. On reset, every output and all internal state go to 0 and the FSM goes to IDLE, including mid-frame. No partial frame is emitted after reset release.

FSM, states IDLE, PREAMBLE, PAYLOAD, DROP:
- IDLE:
  - rx_dv=0: latch link status every cycle from the received byte. link_up = bit0, link_speed = bits[2:1], full_duplex = bit3.
  - rx_dv=1 and byte == 0x55: go to PREAMBLE, preamble count = 1.
  - rx_dv=1 and byte == 0xD5: go to PAYLOAD (short preamble is accepted).
  - rx_dv=1 and any other byte: go to DROP.
  - rx_dv=0 with rx_er=1 (carrier extension or false carrier) is ignored, and link status is not updated that cycle.
- PREAMBLE:
  - rx_dv=0: back to IDLE, error_frame_count += 1.
  - 0x55: count += 1. If the count would exceed MAX_PREAMBLE_BYTES, go to DROP.
  - 0xD5: go to PAYLOAD with byte count = 0 and error flag = 0.
  - Any other byte: go to DROP.
- PAYLOAD:
  - rx_dv=1: load the byte into the hold register and increment the byte count. rx_er=1 on any byte sets a sticky frame error.
  - Hold register: when a new byte arrives and the hold register is occupied, the held byte goes to the output register with last=0.
  - rx_dv=0: the held byte (if any) goes out with last=1 and error = sticky flag; go to IDLE.
  - rx_dv=0 with zero payload bytes: no output, error_frame_count += 1.
  - Truncation: when the byte count reaches MAX_FRAME_BYTES and rx_dv is still 1 on the next byte, emit the held byte with last=1, error=1, and go to DROP.
- DROP: discard everything until rx_dv=0, then go to IDLE with error_frame_count += 1. A truncated frame is counted once, at the last-byte emit, not again on leaving DROP.
- Counters: increment in the cycle data_last is emitted. Error selects which counter. Counters wrap modulo 2^COUNTER_WIDTH.

Latency and output timing:
- A byte present on ddr_data in cycle k appears on data_out in cycle k+2.
- Outputs are registered. data_valid is a single-cycle pulse per byte.
- data_out holds its last value when data_valid=0. data_last and data_error are 0 when data_valid=0.
- Back-to-back frames with a 1-cycle rx_dv=0 gap must both be delivered intact. The last byte of frame A and the preamble of frame B may overlap in time.

Test Plan:
- Reset, then 7×0x55, 0xD5, payload 0x01..0x40 (64 bytes) with rx_dv=1 throughout, then rx_dv=0 → 64 valid bytes 0x01..0x40 starting 2 cycles after the first payload byte; last on 0x40; error=0; good_frame_count=1.
- Same frame with rx_er=1 on payload byte 10 → all 64 bytes emitted; last byte has data_error=1; error_frame_count=1; good_frame_count unchanged.
- 9×0x55 then 0xD5 (exceeds MAX_PREAMBLE_BYTES=7) → no data_valid; error_frame_count += 1 after rx_dv drops.
- Frame of MAX_FRAME_BYTES+5 bytes → exactly MAX_FRAME_BYTES valid bytes; last on byte MAX_FRAME_BYTES with error=1; error_frame_count += 1 (counted once); IDLE after rx_dv=0.
- Idle with rx_dv=0, byte 0x0D → link_up=1, link_speed=10, full_duplex=1. Then rx_dv=0, rx_er=1, byte 0x00 → status unchanged.
- Assert reset_n=0 mid-payload, release, then send a clean 1-byte frame 0xAB → all outputs 0 during reset; no stale bytes; one byte 0xAB with last=1, error=0; good_frame_count=1.
